// File: rtl/offchip_line_bridge_pkg.sv
// Shared configuration for the off-chip line bridge: line geometry and FSM state encodings.
package offchip_line_bridge_pkg;

  localparam int unsigned CacheLineSize = 16;
  localparam int unsigned BusWordBytes  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBeat = 2'd1,
    StDone = 2'd2
  } bridge_st_e;

endpackage

// File: rtl/offchip_line_bridge.sv
// Splits one cache-line refill or writeback into single 32-bit beats on the external bus,
// with rising-edge request detection and one-deep pending flags per request type.
module offchip_line_bridge
  import offchip_line_bridge_pkg::*;
#(
  parameter int unsigned LINE_BYTES = CacheLineSize
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             line_addr,
  input  logic                    line_rd_en,
  input  logic                    line_wr_en,
  input  logic [LINE_BYTES*8-1:0] line_wdata,
  output logic [LINE_BYTES*8-1:0] line_rdata,
  output logic                    line_ready,
  output logic                    line_busy,
  output logic [31:0]             bus_addr,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [31:0]             bus_wdata,
  input  logic [31:0]             bus_rdata,
  input  logic                    bus_ack
);

  localparam int unsigned BEATS = LINE_BYTES / BusWordBytes;
  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);
  localparam logic [31:0] LineMask = 32'(LINE_BYTES - 1);

  typedef logic [BEATS-1:0][31:0] line_t;

  bridge_st_e        state_q, state_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [31:0]       base_q, base_d;
  line_t             wline_q, wline_d;
  line_t             rline_q, rline_d;
  logic              job_wr_q, job_wr_d;
  logic              rd_q, wr_q;
  logic              rd_pend_q, rd_pend_d;
  logic              wr_pend_q, wr_pend_d;

  logic rd_rise, wr_rise, rd_req, wr_req, in_beat;

  assign rd_rise = line_rd_en & ~rd_q;
  assign wr_rise = line_wr_en & ~wr_q;
  assign rd_req  = rd_rise | rd_pend_q;
  assign wr_req  = wr_rise | wr_pend_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    wline_d   = wline_q;
    rline_d   = rline_q;
    job_wr_d  = job_wr_q;
    // Any rise not consumed this cycle is remembered; a repeat while pending is absorbed.
    rd_pend_d = rd_pend_q | rd_rise;
    wr_pend_d = wr_pend_q | wr_rise;

    unique case (state_q)
      StIdle: begin
        if (wr_req) begin
          state_d   = StBeat;
          job_wr_d  = 1'b1;
          base_d    = line_addr & ~LineMask;
          wline_d   = line_wdata;
          beat_d    = '0;
          wr_pend_d = 1'b0;
        end else if (rd_req) begin
          state_d   = StBeat;
          job_wr_d  = 1'b0;
          base_d    = line_addr & ~LineMask;
          beat_d    = '0;
          rd_pend_d = 1'b0;
        end
      end
      StBeat: begin
        if (bus_ack) begin
          if (!job_wr_q) begin
            rline_d[beat_q] = bus_rdata;
          end
          if (beat_q == LastBeat) begin
            state_d = StDone;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      base_q    <= '0;
      wline_q   <= '0;
      rline_q   <= '0;
      job_wr_q  <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      wline_q   <= wline_d;
      rline_q   <= rline_d;
      job_wr_q  <= job_wr_d;
      rd_q      <= line_rd_en;
      wr_q      <= line_wr_en;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  // Bus outputs decode straight from registered state, so they hold steady across wait cycles.
  assign in_beat    = (state_q == StBeat);
  assign bus_req    = in_beat;
  assign bus_we     = in_beat & job_wr_q;
  assign bus_addr   = in_beat ? (base_q + {{(30 - BeatW){1'b0}}, beat_q, 2'b00}) : 32'h0;
  assign bus_wdata  = in_beat ? wline_q[beat_q] : 32'h0;
  assign line_ready = (state_q == StDone);
  assign line_busy  = (state_q != StIdle);
  assign line_rdata = rline_q;

endmodule

// File: tb/tb_offchip_line_bridge.sv
// Directed bench for offchip_line_bridge: a configurable-wait bus responder plus a beat logger.
module tb_offchip_line_bridge;

  localparam int LB = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [31:0]     line_addr = '0;
  logic            line_rd_en = 1'b0;
  logic            line_wr_en = 1'b0;
  logic [LB*8-1:0] line_wdata = '0;
  logic [LB*8-1:0] line_rdata;
  logic            line_ready, line_busy;
  logic [31:0]     bus_addr, bus_wdata;
  logic            bus_req, bus_we;
  logic [31:0]     bus_rdata = '0;
  logic            bus_ack = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  offchip_line_bridge #(.LINE_BYTES(LB)) dut (
    .clk        (clk),
    .rst        (rst),
    .line_addr  (line_addr),
    .line_rd_en (line_rd_en),
    .line_wr_en (line_wr_en),
    .line_wdata (line_wdata),
    .line_rdata (line_rdata),
    .line_ready (line_ready),
    .line_busy  (line_busy),
    .bus_addr   (bus_addr),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
  );

  // Responder: acks each beat after ack_wait idle cycles; read data chosen by word index.
  logic [31:0] rd_words [4];
  int ack_wait = 0;
  int wcnt = 0;
  int c_eff;
  assign c_eff = bus_ack ? 0 : wcnt;

  always @(negedge clk) begin
    if (!rst || !bus_req) begin
      bus_ack <= 1'b0;
      wcnt    <= 0;
    end else if (c_eff >= ack_wait) begin
      bus_ack   <= 1'b1;
      bus_rdata <= rd_words[bus_addr[3:2]];
      wcnt      <= 0;
    end else begin
      bus_ack <= 1'b0;
      wcnt    <= c_eff + 1;
    end
  end

  // Logger of completed beats, ready pulses and request cycles.
  logic [31:0] log_addr  [64];
  logic [31:0] log_wdata [64];
  logic        log_we    [64];
  int log_n = 0;
  int ready_n = 0;
  int req_n = 0;

  always @(posedge clk) begin
    if (bus_req && bus_ack && log_n < 64) begin
      log_addr[log_n]  <= bus_addr;
      log_wdata[log_n] <= bus_wdata;
      log_we[log_n]    <= bus_we;
      log_n            <= log_n + 1;
    end
    if (line_ready) ready_n <= ready_n + 1;
    if (bus_req) req_n <= req_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (bus_req !== 1'b0) $display("FAIL rst_bus_req got %b want 0", bus_req); else n_pass++;
    n_total++; if (bus_we !== 1'b0) $display("FAIL rst_bus_we got %b want 0", bus_we); else n_pass++;
    n_total++; if (bus_addr !== 32'h0) $display("FAIL rst_bus_addr got %h want 0", bus_addr); else n_pass++;
    n_total++; if (bus_wdata !== 32'h0) $display("FAIL rst_bus_wdata got %h want 0", bus_wdata); else n_pass++;
    n_total++; if (line_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", line_ready); else n_pass++;
    n_total++; if (line_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", line_busy); else n_pass++;
    n_total++; if (line_rdata !== '0) $display("FAIL rst_rdata got %h want 0", line_rdata); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    tick();
    n_total++; if (line_busy !== 1'b0) $display("FAIL idle_busy got %b want 0", line_busy); else n_pass++;
  endtask

  task automatic test_zero_read();
    int b, r, rdy_at;
    ack_wait = 0;
    rd_words = '{32'h11, 32'h22, 32'h33, 32'h44};
    line_addr = 32'h0000_1234;
    b = log_n; r = ready_n; rdy_at = -1;
    line_rd_en = 1'b1;
    tick();
    n_total++; if (bus_req !== 1'b1) $display("FAIL zr_req got %b want 1", bus_req); else n_pass++;
    n_total++; if (bus_addr !== 32'h1230) $display("FAIL zr_addr0 got %h want 1230", bus_addr); else n_pass++;
    n_total++; if (line_busy !== 1'b1) $display("FAIL zr_busy got %b want 1", line_busy); else n_pass++;
    for (int k = 2; k <= 7; k++) begin
      tick();
      if (line_ready && rdy_at < 0) rdy_at = k;
    end
    n_total++; if (rdy_at != 5) $display("FAIL zr_ready_cycle got %0d want 5", rdy_at); else n_pass++;
    n_total++; if (ready_n - r != 1) $display("FAIL zr_ready_pulses got %0d want 1", ready_n - r); else n_pass++;
    n_total++; if (log_n - b != 4) $display("FAIL zr_beats got %0d want 4", log_n - b); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (log_addr[b+i] !== 32'h1230 + 32'(4*i) || log_we[b+i] !== 1'b0)
        $display("FAIL zr_beat%0d got addr %h we %b want addr %h we 0", i, log_addr[b+i],
                 log_we[b+i], 32'h1230 + 32'(4*i));
      else n_pass++;
    end
    n_total++;
    if (line_rdata !== 128'h00000044_00000033_00000022_00000011)
      $display("FAIL zr_rdata got %h want 00000044000000330000002200000011", line_rdata);
    else n_pass++;
    line_rd_en = 1'b0;
    tick();
  endtask

  task automatic test_write_waits();
    int b, r, rdy_at;
    logic [127:0] saved, wd;
    ack_wait = 2;
    wd = 128'hDDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666;
    line_addr = 32'h0000_2008;
    line_wdata = wd;
    saved = line_rdata;
    b = log_n; r = ready_n; rdy_at = -1;
    line_wr_en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (line_ready && rdy_at < 0) rdy_at = k;
      if (k <= 3) begin
        n_total++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h2000 ||
            bus_wdata !== 32'h7777_6666)
          $display("FAIL ww_hold%0d got req %b we %b addr %h data %h want 1 1 2000 77776666",
                   k, bus_req, bus_we, bus_addr, bus_wdata);
        else n_pass++;
      end
    end
    n_total++; if (rdy_at != 13) $display("FAIL ww_ready_cycle got %0d want 13", rdy_at); else n_pass++;
    n_total++; if (ready_n - r != 1) $display("FAIL ww_ready_pulses got %0d want 1", ready_n - r); else n_pass++;
    n_total++; if (log_n - b != 4) $display("FAIL ww_beats got %0d want 4", log_n - b); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (log_we[b+i] !== 1'b1 || log_addr[b+i] !== 32'h2000 + 32'(4*i) ||
          log_wdata[b+i] !== wd[32*i +: 32])
        $display("FAIL ww_beat%0d got we %b addr %h data %h want 1 %h %h", i, log_we[b+i],
                 log_addr[b+i], log_wdata[b+i], 32'h2000 + 32'(4*i), wd[32*i +: 32]);
      else n_pass++;
    end
    n_total++; if (line_rdata !== saved) $display("FAIL ww_rdata got %h want %h", line_rdata, saved); else n_pass++;
    line_wr_en = 1'b0;
    tick();
  endtask

  task automatic test_refill_writeback();
    int b, r, first, second;
    logic [127:0] wd;
    ack_wait = 0;
    rd_words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    wd = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    line_addr = 32'h0000_3000;
    b = log_n; r = ready_n; first = -1; second = -1;
    line_rd_en = 1'b1;
    tick();
    tick();
    tick();
    line_wr_en = 1'b1;
    line_addr = 32'h0000_4000;
    line_wdata = wd;
    for (int k = 4; k <= 14; k++) begin
      tick();
      if (line_ready) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    n_total++; if (first != 5) $display("FAIL rw_first_ready got %0d want 5", first); else n_pass++;
    n_total++; if (second != 11) $display("FAIL rw_second_ready got %0d want 11", second); else n_pass++;
    n_total++; if (ready_n - r != 2) $display("FAIL rw_ready_pulses got %0d want 2", ready_n - r); else n_pass++;
    n_total++; if (log_n - b != 8) $display("FAIL rw_beats got %0d want 8", log_n - b); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (log_we[b+i] !== 1'b0 || log_addr[b+i] !== 32'h3000 + 32'(4*i))
        $display("FAIL rw_rd%0d got we %b addr %h want 0 %h", i, log_we[b+i], log_addr[b+i],
                 32'h3000 + 32'(4*i));
      else n_pass++;
      n_total++;
      if (log_we[b+4+i] !== 1'b1 || log_addr[b+4+i] !== 32'h4000 + 32'(4*i) ||
          log_wdata[b+4+i] !== wd[32*i +: 32])
        $display("FAIL rw_wr%0d got we %b addr %h data %h want 1 %h %h", i, log_we[b+4+i],
                 log_addr[b+4+i], log_wdata[b+4+i], 32'h4000 + 32'(4*i), wd[32*i +: 32]);
      else n_pass++;
    end
    n_total++;
    if (line_rdata !== 128'h000000A3_000000A2_000000A1_000000A0)
      $display("FAIL rw_rdata got %h want 000000a3000000a2000000a1000000a0", line_rdata);
    else n_pass++;
    line_wr_en = 1'b0;
  endtask

  task automatic test_held_enable();
    int q, r;
    q = req_n; r = ready_n;
    repeat (20) tick();
    n_total++; if (req_n != q) $display("FAIL held_req got %0d want %0d", req_n, q); else n_pass++;
    n_total++; if (ready_n != r) $display("FAIL held_ready got %0d want %0d", ready_n, r); else n_pass++;
    n_total++; if (line_busy !== 1'b0) $display("FAIL held_busy got %b want 0", line_busy); else n_pass++;
    line_rd_en = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    int b, r, first, second;
    logic [127:0] wd;
    ack_wait = 0;
    rd_words = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    wd = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    line_addr = 32'h0000_5000;
    line_wdata = wd;
    b = log_n; r = ready_n; first = -1; second = -1;
    line_rd_en = 1'b1;
    line_wr_en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (line_ready) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    n_total++; if (first != 5) $display("FAIL sim_first_ready got %0d want 5", first); else n_pass++;
    n_total++; if (second != 11) $display("FAIL sim_second_ready got %0d want 11", second); else n_pass++;
    n_total++; if (log_n - b != 8) $display("FAIL sim_beats got %0d want 8", log_n - b); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (log_we[b+i] !== 1'b1 || log_wdata[b+i] !== wd[32*i +: 32])
        $display("FAIL sim_wr%0d got we %b data %h want 1 %h", i, log_we[b+i], log_wdata[b+i],
                 wd[32*i +: 32]);
      else n_pass++;
      n_total++;
      if (log_we[b+4+i] !== 1'b0 || log_addr[b+4+i] !== 32'h5000 + 32'(4*i))
        $display("FAIL sim_rd%0d got we %b addr %h want 0 %h", i, log_we[b+4+i],
                 log_addr[b+4+i], 32'h5000 + 32'(4*i));
      else n_pass++;
    end
    n_total++;
    if (line_rdata !== 128'h000000C3_000000C2_000000C1_000000C0)
      $display("FAIL sim_rdata got %h want 000000c3000000c2000000c1000000c0", line_rdata);
    else n_pass++;
    line_rd_en = 1'b0;
    line_wr_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int b, r;
    ack_wait = 0;
    rd_words = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    line_addr = 32'h0000_6000;
    line_rd_en = 1'b1;
    tick();
    tick();
    tick();
    n_total++;
    if (line_rdata[63:0] !== 64'h000000D1_000000D0)
      $display("FAIL rm_partial got %h want 000000d1000000d0", line_rdata[63:0]);
    else n_pass++;
    #1 rst = 1'b0;
    #1;
    n_total++; if (bus_req !== 1'b0) $display("FAIL rm_req got %b want 0", bus_req); else n_pass++;
    n_total++; if (line_busy !== 1'b0) $display("FAIL rm_busy got %b want 0", line_busy); else n_pass++;
    n_total++; if (line_ready !== 1'b0) $display("FAIL rm_ready got %b want 0", line_ready); else n_pass++;
    n_total++; if (line_rdata !== '0) $display("FAIL rm_rdata got %h want 0", line_rdata); else n_pass++;
    line_rd_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    b = log_n; r = ready_n;
    line_rd_en = 1'b1;
    tick();
    n_total++; if (bus_addr !== 32'h6000) $display("FAIL rm_restart_addr got %h want 6000", bus_addr); else n_pass++;
    repeat (6) tick();
    n_total++; if (ready_n - r != 1) $display("FAIL rm_ready_pulses got %0d want 1", ready_n - r); else n_pass++;
    n_total++; if (log_n - b != 4) $display("FAIL rm_beats got %0d want 4", log_n - b); else n_pass++;
    n_total++;
    if (line_rdata !== 128'h000000D3_000000D2_000000D1_000000D0)
      $display("FAIL rm_rdata got %h want 000000d3000000d2000000d1000000d0", line_rdata);
    else n_pass++;
    line_rd_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_read();
    test_write_waits();
    test_refill_writeback();
    test_held_enable();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
